// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer.
//   sb_entry_t  - one buffered store: word address, lane-aligned data and byte mask
//   sb_state_e  - memory issue FSM state (IDLE: no request, ISSUE: mem_req high)
//   merge_bytes - overlays the enabled byte lanes of new data onto old data
package store_buffer_pkg;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_ISSUE = 1'b1
  } sb_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                              input logic [31:0] new_data,
                                              input logic [3:0]  new_mask);
    logic [31:0] result;
    result = old_data;
    for (int lane = 0; lane < 4; lane++) begin
      if (new_mask[lane]) begin
        result[8*lane +: 8] = new_data[8*lane +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/store_buffer_fwd_merge.sv
// store_fwd_merge: combinational store-to-load forwarding lookup.
// Entries arrive ordered by age (index 0 = oldest). For each byte lane the
// youngest valid entry whose word address matches and whose mask enables that
// lane supplies the byte.
//   entries_i      - age-ordered buffered entries
//   valid_i        - per-slot valid flags (same ordering)
//   ld_word_addr_i - word address of the load
//   fwd_data_o     - forwarded bytes, unmatched lanes zero
//   fwd_mask_o     - lanes of fwd_data_o that hold forwarded bytes
module store_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t [DEPTH-1:0] entries_i,
  input  logic      [DEPTH-1:0] valid_i,
  input  logic      [29:0]      ld_word_addr_i,
  output logic      [31:0]      fwd_data_o,
  output logic      [3:0]       fwd_mask_o
);

  // Walking oldest to youngest lets each younger match simply overwrite
  // its lanes, so the youngest writer wins without a priority encoder.
  always_comb begin
    fwd_data_o = '0;
    fwd_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && (entries_i[i].word_addr == ld_word_addr_i)) begin
        fwd_data_o = merge_bytes(fwd_data_o, entries_i[i].data, entries_i[i].mask);
        fwd_mask_o = fwd_mask_o | entries_i[i].mask;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between the datapath and data memory.
// Stores are queued in a DEPTH-entry FIFO; the head entry is presented to
// memory until acknowledged. Loads can pick up pending bytes via forwarding.
// Optional feature macro: STORE_BUFFER_COALESCE_EN merges a store into the
// youngest entry when it targets the same word and that entry is not the one
// currently being issued.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   st_valid/st_addr/st_data/st_mask  - incoming store
//   st_ready                          - store accepted when st_valid && st_ready
//   ld_addr, ld_fwd_data, ld_fwd_mask - forwarding lookup
//   mem_req/mem_addr/mem_wdata/mem_wmask, mem_ack - memory write handshake
//   empty                             - nothing pending and no request outstanding
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_mask,
  output logic        st_ready,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_fwd_data,
  output logic [3:0]  ld_fwd_mask,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  sb_state_e        state_q, state_d;

  logic      full;
  logic      push_fire;
  logic      do_alloc;
  logic      do_pop;
  logic      coalesce_hit;
  sb_entry_t head_entry;
  sb_entry_t new_entry;

  // Byte offset bits carry no information for a word-granular buffer.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign full       = (count_q == CNT_W'(DEPTH));
  assign head_entry = entries_q[head_q];
  assign new_entry  = '{word_addr: st_addr[31:2], data: st_data, mask: st_mask};

`ifdef STORE_BUFFER_COALESCE_EN
  logic [PTR_W-1:0] last_idx;
  logic             do_coalesce;

  // The youngest entry may absorb the store unless it is the only entry and
  // is already on the memory bus. A hit also accepts stores while full.
  assign last_idx     = tail_q - PTR_W'(1);
  assign coalesce_hit = (count_q != '0)
                     && (entries_q[last_idx].word_addr == st_addr[31:2])
                     && !(mem_req && (count_q == CNT_W'(1)));
  assign st_ready     = !full || coalesce_hit;
  assign do_coalesce  = push_fire && (st_mask != 4'b0000) && coalesce_hit;
`else
  assign coalesce_hit = 1'b0;
  assign st_ready     = !full;
`endif

  // Zero-mask stores are accepted but leave no trace.
  assign push_fire = st_valid && st_ready;
  assign do_alloc  = push_fire && (st_mask != 4'b0000) && !coalesce_hit;
  assign do_pop    = mem_req && mem_ack;

  assign head_d  = do_pop   ? head_q + PTR_W'(1) : head_q;
  assign tail_d  = do_alloc ? tail_q + PTR_W'(1) : tail_q;
  assign count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);

  // Next-state logic looks at the post-update count so a store into an empty
  // buffer is on the bus in the very next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE:  if (count_d != '0) state_d = SB_ISSUE;
      SB_ISSUE: if (do_pop && (count_d == '0)) state_d = SB_IDLE;
      default:  state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= SB_IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      entries_q[tail_q] <= new_entry;
    end
`ifdef STORE_BUFFER_COALESCE_EN
    if (do_coalesce) begin
      entries_q[last_idx] <= '{word_addr: entries_q[last_idx].word_addr,
                               data:      merge_bytes(entries_q[last_idx].data, st_data, st_mask),
                               mask:      entries_q[last_idx].mask | st_mask};
    end
`endif
  end

  assign mem_req   = (state_q == SB_ISSUE);
  assign mem_addr  = head_entry.word_addr;
  assign mem_wdata = head_entry.data;
  assign mem_wmask = head_entry.mask;
  assign empty     = (count_q == '0) && !mem_req;

  // Present the ring contents to the forwarding unit oldest-first.
  sb_entry_t [DEPTH-1:0] ordered_entries;
  logic      [DEPTH-1:0] ordered_valid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ordered_entries[i] = entries_q[head_q + PTR_W'(i)];
      ordered_valid[i]   = (CNT_W'(i) < count_q);
    end
  end

  store_fwd_merge #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .entries_i      (ordered_entries),
    .valid_i        (ordered_valid),
    .ld_word_addr_i (ld_addr[31:2]),
    .fwd_data_o     (ld_fwd_data),
    .fwd_mask_o     (ld_fwd_mask)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model of the buffer.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_fwd_data;
  logic [3:0]  ld_fwd_mask;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic        empty;

  store_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_mask     (st_mask),
    .st_ready    (st_ready),
    .ld_addr     (ld_addr),
    .ld_fwd_data (ld_fwd_data),
    .ld_fwd_mask (ld_fwd_mask),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_ack     (mem_ack),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  mask;
  } ref_entry_t;

  ref_entry_t refQ[$];
  logic       refReq = 1'b0;
  int         compared = 0;
  int         mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Whether the model would fold a store to this word into its youngest entry.
  function automatic bit refCanMerge(input logic [29:0] wa);
`ifdef STORE_BUFFER_COALESCE_EN
    if (refQ.size() == 0) return 1'b0;
    if (refQ[refQ.size()-1].wa != wa) return 1'b0;
    if (refReq && (refQ.size() == 1)) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Per lane, scan from youngest to oldest and take the first writer.
  task automatic refForward(input logic [29:0] wa, output logic [31:0] d, output logic [3:0] m);
    d = '0;
    m = '0;
    for (int lane = 0; lane < 4; lane++) begin
      for (int j = refQ.size() - 1; j >= 0; j--) begin
        if ((refQ[j].wa == wa) && refQ[j].mask[lane]) begin
          d[8*lane +: 8] = refQ[j].data[8*lane +: 8];
          m[lane] = 1'b1;
          break;
        end
      end
    end
  endtask

  // Drives one cycle of inputs, checks all outputs against the model just
  // before the rising edge, then advances the model across that edge.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask,
                               input logic ack, input logic [31:0] ldAddr);
    logic        expReady;
    logic        mergeHit;
    logic [31:0] expData;
    logic [3:0]  expMask;
    ref_entry_t  e;
    reset    = rst;
    st_valid = valid;
    st_addr  = addr;
    st_data  = data;
    st_mask  = mask;
    mem_ack  = ack;
    ld_addr  = ldAddr;
    #1;
    mergeHit = refCanMerge(addr[31:2]);
    expReady = (refQ.size() < DEPTH) || mergeHit;
    checkOutput("st_ready", st_ready, expReady);
    checkOutput("mem_req", mem_req, refReq);
    if (refReq && (refQ.size() > 0)) begin
      checkOutput("mem_addr", mem_addr, refQ[0].wa);
      checkOutput("mem_wdata", mem_wdata, refQ[0].data);
      checkOutput("mem_wmask", mem_wmask, refQ[0].mask);
    end
    refForward(ldAddr[31:2], expData, expMask);
    checkOutput("fwd_data", ld_fwd_data, expData);
    checkOutput("fwd_mask", ld_fwd_mask, expMask);
    checkOutput("empty", empty, (refQ.size() == 0) && !refReq);
    @(posedge clk);
    if (rst) begin
      refQ.delete();
      refReq = 1'b0;
    end else begin
      if (valid && expReady && (mask != 4'b0000) && mergeHit) begin
        e = refQ.pop_back();
        for (int lane = 0; lane < 4; lane++) begin
          if (mask[lane]) e.data[8*lane +: 8] = data[8*lane +: 8];
        end
        e.mask = e.mask | mask;
        refQ.push_back(e);
      end
      if (refReq && ack) void'(refQ.pop_front());
      if (valid && expReady && (mask != 4'b0000) && !mergeHit) begin
        e.wa   = addr[31:2];
        e.data = data;
        e.mask = mask;
        refQ.push_back(e);
      end
      refReq = (refQ.size() != 0);
    end
    @(negedge clk);
  endtask

  task automatic idleCycle(input logic ack);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ack, 32'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < 3 * DEPTH && refQ.size() > 0; k++) idleCycle(1'b1);
    idleCycle(1'b0);
  endtask

  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int writes;
    logic [31:0] a;
    logic [31:0] la;

    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
    mem_ack = 1'b0; ld_addr = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_ready", st_ready, 1'b1);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_memreq", mem_req, 1'b0);
    checkOutput("rst_fwdmask", ld_fwd_mask, 4'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);

    $display("[TB] single store with delayed ack");
    applyStimulus(1'b0, 1'b1, 32'h10010008, 32'hCAFEBABE, 4'hF, 1'b0, 32'h0);
    checkOutput("s1_req", mem_req, 1'b1);
    checkOutput("s1_addr", mem_addr, 32'h04004002);
    checkOutput("s1_wdata", mem_wdata, 32'hCAFEBABE);
    idleCycle(1'b0);
    checkOutput("s1_hold", mem_wdata, 32'hCAFEBABE);
    idleCycle(1'b1);
    checkOutput("s1_empty", empty, 1'b1);

    $display("[TB] fill to full");
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b1, 32'h10020000 + 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF, 1'b0, 32'h0);
    checkOutput("full_ready", st_ready, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h10020040, 32'h55555555, 4'hF, 1'b1, 32'h0);
    checkOutput("full_after_pop", st_ready, 1'b1);
    checkOutput("full_order", mem_addr, 32'h04008001);
    drain();

    $display("[TB] forwarding youngest wins");
    applyStimulus(1'b0, 1'b1, 32'h1001000C, 32'hBEEFDEAD, 4'b0011, 1'b0, 32'h1001000C);
    applyStimulus(1'b0, 1'b1, 32'h1001000C, 32'hCAFEBABE, 4'b0110, 1'b0, 32'h1001000C);
    checkOutput("fwd_mask_dir", ld_fwd_mask, 4'b0111);
    checkOutput("fwd_data_dir", ld_fwd_data, 32'h00FEBAAD);
    drain();

    $display("[TB] same-word stores behind a busy head");
    applyStimulus(1'b0, 1'b1, 32'h10030000, 32'h11111111, 4'hF, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1001000C, 32'hAABB0000, 4'b1100, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1001000C, 32'h0000CCDD, 4'b0011, 1'b0, 32'h0);
    writes = 0;
    for (int k = 0; k < 10; k++) begin
      if (mem_req) writes++;
      idleCycle(1'b1);
    end
`ifdef STORE_BUFFER_COALESCE_EN
    checkOutput("coalesce_writes", writes, 2);
`else
    checkOutput("coalesce_writes", writes, 3);
`endif

    $display("[TB] zero-mask store");
    applyStimulus(1'b0, 1'b1, 32'h10040000, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0);
    checkOutput("zmask_req", mem_req, 1'b0);
    checkOutput("zmask_empty", empty, 1'b1);

    $display("[TB] reset while issuing");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 32'h10050000 + 32'(4 * i), 32'hD0000000 + 32'(i), 4'hF, 1'b0, 32'h0);
    checkOutput("midrst_req_before", mem_req, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0);
    checkOutput("midrst_req", mem_req, 1'b0);
    checkOutput("midrst_empty", empty, 1'b1);
    writes = 0;
    for (int k = 0; k < 3; k++) begin
      if (mem_req) writes++;
      idleCycle(1'b1);
    end
    checkOutput("midrst_writes", writes, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 500; n++) begin
      a  = 32'h10010000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      la = 32'h10010000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 3) != 0),
                    a, $urandom, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), la);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered store entries (power of two, >=2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: st_valid  input  1  datapath presents a store this cycle.
REQ-005 Port: st_addr  input  32  byte address of store; bits [1:0] ignored.
REQ-006 Port: st_data  input  32  store data, already lane-aligned.
REQ-007 Port: st_mask  input  4  byte enables, bit i = byte lane i.
REQ-008 Port: st_ready  output  1  store accepted when st_valid && st_ready.
REQ-009 Port: ld_addr  input  32  load byte address for forwarding lookup.
REQ-010 Port: ld_fwd_data  output  32  forwarded bytes from pending stores.
REQ-011 Port: ld_fwd_mask  output  4  lanes of ld_fwd_data that are valid.
REQ-012 Port: mem_req  output  1  write request to data memory.
REQ-013 Port: mem_addr  output  30  word address (st_addr[31:2]) of request.
REQ-014 Port: mem_wdata  output  32  write data.
REQ-015 Port: mem_wmask  output  4  byte write enables.
REQ-016 Port: mem_ack  input  1  memory accepted the request this cycle.
REQ-017 Port: empty  output  1  no entries pending and no request outstanding.

Function
REQ-018 FIFO of DEPTH entries {word_addr, data, mask}; head issues, tail accepts.
REQ-019 st_ready = !full; a pop in the same cycle does not free a slot for that cycle's push.
REQ-020 Accepted store with st_mask==4'b0000 is consumed and creates no entry.
REQ-021 Issue FSM states: IDLE (mem_req=0), ISSUE (mem_req=1); IDLE->ISSUE when count>0; ISSUE->IDLE on mem_ack when count becomes 0, else stays ISSUE with next head.
REQ-022 mem_addr/mem_wdata/mem_wmask driven from head entry and held stable while mem_req=1 and mem_ack=0.
REQ-023 Head pops on the cycle mem_req && mem_ack; mem_ack while mem_req=0 is ignored.
REQ-024 Latency: store accepted at edge N into empty buffer -> mem_req high in cycle following edge N (earliest ack at edge N+1).
REQ-025 Simultaneous push and pop when not full: both take effect; count unchanged.
REQ-026 Forwarding combinational: per lane, youngest pending entry with matching word_addr and mask bit set supplies the byte; ld_fwd_mask bit set iff any such entry; unmatched lanes of ld_fwd_data = 0.
REQ-027 Forwarding includes the head entry while it is being issued, excludes a store being pushed in the same cycle.
REQ-028 Pointers wrap modulo DEPTH; count has log2(DEPTH)+1 bits; full = count==DEPTH.
REQ-029 empty = (count==0) && !mem_req.

Reset
REQ-030 On reset: count=0, pointers=0, FSM=IDLE, mem_req=0, st_ready=1, empty=1, ld_fwd_mask=0.
REQ-031 Reset mid-operation discards all pending entries; mem_req low the cycle after reset is sampled, regardless of mem_ack.

Configuration
REQ-032 Macro STORE_BUFFER_COALESCE_EN: when defined, a store whose word address matches the tail entry, where tail is not the entry currently issued, merges into it (new bytes overwrite per mask, masks ORed) and allocates no entry; coalescing is allowed when full.
REQ-033 Without STORE_BUFFER_COALESCE_EN every nonzero-mask store allocates its own entry.

Structure
REQ-034 Shared package holds entry struct {word_addr[29:0], data[31:0], mask[3:0]}, FSM state enum, and byte-merge function.
REQ-035 One sub-module natural: store_fwd_merge (combinational youngest-wins per-lane match over entries).

Verification
REQ-036 Store 0xCAFEBABE mask 4'hF to 0x10010008, mem_ack after 2 cycles -> mem_addr=0x04004002, wdata=0xCAFEBABE held 2 cycles, empty=1 after ack.
REQ-037 Fill 4 stores with mem_ack=0 -> st_ready=0 on 5th; one ack -> st_ready=1 next cycle, order preserved.
REQ-038 Pending 0xBEEFDEAD mask 4'b0011 at 0x1001000C then 0xCAFEBABE mask 4'b0110 same word; ld_addr=0x1001000C -> ld_fwd_mask=4'b0111, ld_fwd_data=0x00FEBAAD.
REQ-039 With COALESCE_EN and head busy, two stores to 0x1001000C masks 4'b1100/4'b0011 -> one entry mask 4'hF; without macro -> two mem writes.
REQ-040 Reset asserted while mem_req=1 with 3 entries -> mem_req=0, empty=1, no further writes.
REQ-041 Store with mask 4'b0000 -> accepted, no mem_req, empty stays 1.
